tick_feed_sequencer: RTL
========================

Name: tick_feed_sequencer

Overview:
- Programmable scheduler that sequences reads from the tick-data ROM and issues one-cycle enable pulses with the fetched sample to the trading logic unit (TLU).
- Replaces a fixed free-running divider with start, stop and single-step control, a configurable tick interval, address-range playback with optional looping, and a tick counter.
- Sits between the ROM and the TLU in the trading top level: drives the ROM address, drives TLU enable and data_in, and observes the TLU result-valid output.

Parameters:
- ADDR_WIDTH, 16, ROM address width.
- DATA_WIDTH, 16, ROM / TLU sample width.
- INTERVAL_WIDTH, 16, width of the programmable gap counter.
- ROM_LATENCY, 1, cycles from rom_addr change to valid rom_dout; must be >= 1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  pulse; latch config and begin continuous playback (IDLE only)
- stop  in  1  pulse; abort playback, return to IDLE
- step  in  1  pulse; fetch and issue exactly one tick (IDLE only)
- interval  in  INTERVAL_WIDTH  idle cycles between ticks
- base_addr  in  ADDR_WIDTH  first sample address
- end_addr  in  ADDR_WIDTH  last sample address
- wrap_en  in  1  1 = loop back to base_addr after end_addr
- rom_addr  out  ADDR_WIDTH  ROM address
- rom_dout  in  DATA_WIDTH  ROM read data
- tlu_result_valid  in  1  TLU data_valid_end
- tick_data  out  DATA_WIDTH  sample to TLU data_in
- tick_valid  out  1  one-cycle pulse to TLU enable
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse when a non-wrapping run completes
- tick_count  out  32  ticks issued since last start

Behaviour:
- Reset values: rom_addr=0, tick_data=0, tick_valid=0, busy=0, done=0, tick_count=0, state=IDLE, step_mode=0.
- States and transitions:
  - IDLE: on start, latch interval, base_addr, end_addr and wrap_en into shadow registers; set rom_addr=base_addr; clear tick_count; step_mode=0; go to FETCH.
  - IDLE: on step, use the latched shadow config (base_addr if no prior start since reset); rom_addr holds the current playback pointer; step_mode=1; go to FETCH.
  - IDLE: start and step in the same cycle: start wins. Both are ignored outside IDLE.
  - FETCH: hold rom_addr for ROM_LATENCY cycles (internal latency counter), then go to LATCH.
  - LATCH: rom_dout is valid this cycle. At the clock edge, tick_data <= rom_dout and tick_valid <= 1 (registered, so tick_valid is high in the following cycle only); tick_count increments, saturating at 0xFFFF_FFFF.
  - LATCH, next state:
    - step_mode=1: advance the pointer, go to IDLE.
    - rom_addr == end_addr and wrap_en=0: go to IDLE with a done pulse in the next cycle; rom_addr holds.
    - Otherwise: rom_addr <= (rom_addr == end_addr) ? base_addr : rom_addr+1, wrapping modulo 2^ADDR_WIDTH; go to GAP, or straight to FETCH if interval == 0.
  - GAP: count interval cycles, then go to FETCH.
- Tick period = interval + ROM_LATENCY + 1 cycles. For example, interval=59 with ROM_LATENCY=1 gives 61 cycles.
- end_addr < base_addr is legal: the address increments through the modulo wrap until it equals end_addr.
- stop while state != IDLE: next state is IDLE and no further tick_valid is issued, except a tick_valid already registered by a LATCH in the same cycle; rom_addr, tick_data and tick_count hold; no done pulse.
- stop in IDLE: no effect.
- tick_valid and done are never high for more than one consecutive cycle.
- Asynchronous reset mid-run: immediate return to reset values; in-flight tick is dropped.

Optional Feature:
- Macro TLU_RESULT_GATE_EN.
- Defined: the sequencer tracks one outstanding tick, set on tick_valid and cleared on tlu_result_valid. GAP (or the LATCH -> FETCH transition when interval=0) does not advance to FETCH while a tick is outstanding; the period stretches accordingly. stop and reset clear the outstanding flag.
- Undefined: tlu_result_valid is ignored and the period is exact.

Test Plan:
- ROM[a]=a+100; start with base=0, end=3, interval=4, wrap=0 -> tick_valid pulses 6 cycles apart with tick_data 100, 101, 102, 103; done pulses once, one cycle after the last LATCH; tick_count=4; busy low afterwards.
- base=0xFFFE, end=0x0001, interval=0, wrap=1 -> tick_data sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001, 0xFFFE, ... (ROM values at those addresses) with ticks every 2 cycles; done never asserts.
- After the first run (pointer at 3), three step pulses spaced 10 cycles apart -> exactly 3 ticks, each returning to IDLE; no GAP state; done=0; start+step in the same cycle -> start behaviour.
- stop asserted during GAP of the 2nd tick -> IDLE next cycle; no further tick_valid; tick_count=2; start again -> restarts at base with tick_count cleared to 0 then counting.
- rst asserted mid-FETCH -> all outputs at reset values; a later start with interval=59 -> 61-cycle tick period.
- With TLU_RESULT_GATE_EN, interval=2, tlu_result_valid returned 10 cycles after each tick -> next tick_valid 11+ROM_LATENCY+1 cycles after the previous one; without the macro -> 4 cycles.

Source files
------------

// File: rtl/tick_feed_sequencer_if.sv
// Bundle of control, ROM and TLU signals around the tick feed sequencer.
// The master side is the environment (controller, ROM, TLU); the slave side is the sequencer.
interface tick_feed_sequencer_if #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int INTERVAL_WIDTH = 16
);
  logic                      start;
  logic                      stop;
  logic                      step;
  logic [INTERVAL_WIDTH-1:0] interval;
  logic [ADDR_WIDTH-1:0]     base_addr;
  logic [ADDR_WIDTH-1:0]     end_addr;
  logic                      wrap_en;
  logic [ADDR_WIDTH-1:0]     rom_addr;
  logic [DATA_WIDTH-1:0]     rom_dout;
  logic                      tlu_result_valid;
  logic [DATA_WIDTH-1:0]     tick_data;
  logic                      tick_valid;
  logic                      busy;
  logic                      done;
  logic [31:0]               tick_count;

  modport master (
    output start, stop, step, interval, base_addr, end_addr, wrap_en,
    output rom_dout, tlu_result_valid,
    input  rom_addr, tick_data, tick_valid, busy, done, tick_count
  );

  modport slave (
    input  start, stop, step, interval, base_addr, end_addr, wrap_en,
    input  rom_dout, tlu_result_valid,
    output rom_addr, tick_data, tick_valid, busy, done, tick_count
  );
endinterface

// File: rtl/tick_feed_sequencer.sv
// Scheduler that walks a ROM address range and feeds one-cycle tick pulses to the TLU.
// Optional macro TLU_RESULT_GATE_EN holds off the next fetch until the TLU answers the last tick.
//
// state | meaning
// IDLE  | waiting for start or step
// FETCH | rom_addr stable, waiting ROM_LATENCY cycles
// LATCH | rom_dout valid, register tick and pick next address
// GAP   | idle interval between ticks
module tick_feed_sequencer #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int INTERVAL_WIDTH = 16,
  parameter int ROM_LATENCY    = 1
) (
  input logic                 clk,
  input logic                 rst,
  tick_feed_sequencer_if.slave bus
);

  localparam int LAT_W = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_LATCH = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_next_state;

  logic [INTERVAL_WIDTH-1:0] r_interval;
  logic [ADDR_WIDTH-1:0]     r_base;
  logic [ADDR_WIDTH-1:0]     r_end;
  logic                      r_wrap;
  logic                      r_step_mode;
  logic [ADDR_WIDTH-1:0]     r_rom_addr;
  logic [DATA_WIDTH-1:0]     r_tick_data;
  logic                      r_tick_valid;
  logic                      r_done;
  logic [31:0]               r_tick_count;
  logic [LAT_W-1:0]          r_lat_cnt;
  logic [INTERVAL_WIDTH-1:0] r_gap_cnt;

  logic                      w_stop;
  logic                      w_start_run;
  logic                      w_step_run;
  logic                      w_enter_fetch;
  logic                      w_enter_gap;
  logic                      w_issue;
  logic                      w_advance;
  logic                      w_done;
  logic                      w_outstanding;
  logic                      w_at_end;
  logic [ADDR_WIDTH-1:0]     w_addr_next;
  logic [INTERVAL_WIDTH-1:0] w_gap_load;

  assign w_stop      = bus.stop & (r_state != S_IDLE);
  assign w_at_end    = (r_rom_addr == r_end);
  assign w_addr_next = w_at_end ? r_base : (r_rom_addr + ADDR_WIDTH'(1));
  assign w_gap_load  = (r_interval == '0) ? '0 : (r_interval - INTERVAL_WIDTH'(1));

`ifdef TLU_RESULT_GATE_EN
  logic r_outstanding;

  // A result arriving in the same cycle as the tick retires it immediately.
  assign w_outstanding = (r_outstanding | r_tick_valid) & ~bus.tlu_result_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outstanding <= 1'b0;
    end else begin
      r_outstanding <= w_stop ? 1'b0 : w_outstanding;
    end
  end
`else
  logic w_unused_result;

  assign w_outstanding   = 1'b0;
  assign w_unused_result = bus.tlu_result_valid;
`endif

  always_comb begin
    w_next_state  = r_state;
    w_start_run   = 1'b0;
    w_step_run    = 1'b0;
    w_enter_fetch = 1'b0;
    w_enter_gap   = 1'b0;
    w_issue       = 1'b0;
    w_advance     = 1'b0;
    w_done        = 1'b0;

    if (w_stop) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            w_start_run   = 1'b1;
            w_enter_fetch = 1'b1;
            w_next_state  = S_FETCH;
          end else if (bus.step) begin
            w_step_run    = 1'b1;
            w_enter_fetch = 1'b1;
            w_next_state  = S_FETCH;
          end
        end
        S_FETCH: begin
          if (r_lat_cnt == '0) begin
            w_next_state = S_LATCH;
          end
        end
        S_LATCH: begin
          w_issue = 1'b1;
          if (r_step_mode) begin
            w_advance    = 1'b1;
            w_next_state = S_IDLE;
          end else if (w_at_end && !r_wrap) begin
            w_done       = 1'b1;
            w_next_state = S_IDLE;
          end else begin
            w_advance = 1'b1;
            if (r_interval == '0 && !w_outstanding) begin
              w_enter_fetch = 1'b1;
              w_next_state  = S_FETCH;
            end else begin
              w_enter_gap  = 1'b1;
              w_next_state = S_GAP;
            end
          end
        end
        S_GAP: begin
          if (r_gap_cnt == '0 && !w_outstanding) begin
            w_enter_fetch = 1'b1;
            w_next_state  = S_FETCH;
          end
        end
        default: begin
          w_next_state = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_interval   <= '0;
      r_base       <= '0;
      r_end        <= '0;
      r_wrap       <= 1'b0;
      r_step_mode  <= 1'b0;
      r_rom_addr   <= '0;
      r_tick_data  <= '0;
      r_tick_valid <= 1'b0;
      r_done       <= 1'b0;
      r_tick_count <= '0;
      r_lat_cnt    <= '0;
      r_gap_cnt    <= '0;
    end else begin
      r_tick_valid <= w_issue;
      r_done       <= w_done;

      if (w_start_run) begin
        r_interval   <= bus.interval;
        r_base       <= bus.base_addr;
        r_end        <= bus.end_addr;
        r_wrap       <= bus.wrap_en;
        r_rom_addr   <= bus.base_addr;
        r_tick_count <= '0;
        r_step_mode  <= 1'b0;
      end else if (w_step_run) begin
        r_step_mode <= 1'b1;
      end

      if (w_enter_fetch) begin
        r_lat_cnt <= LAT_W'(ROM_LATENCY - 1);
      end else if (r_state == S_FETCH && r_lat_cnt != '0) begin
        r_lat_cnt <= r_lat_cnt - LAT_W'(1);
      end

      if (w_enter_gap) begin
        r_gap_cnt <= w_gap_load;
      end else if (r_state == S_GAP && r_gap_cnt != '0) begin
        r_gap_cnt <= r_gap_cnt - INTERVAL_WIDTH'(1);
      end

      if (w_issue) begin
        r_tick_data <= bus.rom_dout;
        if (r_tick_count != 32'hFFFF_FFFF) begin
          r_tick_count <= r_tick_count + 32'd1;
        end
      end

      if (w_advance) begin
        r_rom_addr <= w_addr_next;
      end
    end
  end

  assign bus.rom_addr   = r_rom_addr;
  assign bus.tick_data  = r_tick_data;
  assign bus.tick_valid = r_tick_valid;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.done       = r_done;
  assign bus.tick_count = r_tick_count;

endmodule
